instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 The block SHALL provide the following ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level sampled in IDLE; begins the program at address 0.
- stall  in  1  downstream hold; freezes issue and all state.
- imem_addr  out  8  instruction memory address (synchronous read, 1-cycle latency).
- imem_rdata  in  16  instruction word: [15:13] opcode, [12:8] element count minus 1, [7:0] base address.
- op_code  out  3  opcode to the control unit.
- issue_valid  out  1  op_code/elem_idx/elem_addr are valid this cycle.
- elem_idx  out  5  current vector element index.
- elem_addr  out  8  base + elem_idx, modulo 256.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on HALT.

Function
REQ-003 The FSM SHALL have the states IDLE, FETCH, LOAD, ISSUE and DONE, with the following transitions:
- IDLE->FETCH: start=1.
- FETCH->LOAD: unconditional.
- LOAD->ISSUE: executable opcode.
- LOAD->FETCH: NOP.
- LOAD->DONE: HALT.
- ISSUE->FETCH: last element accepted.
- DONE->IDLE: unconditional.
REQ-004 The PC SHALL be 8 bits and cleared to 0 when leaving IDLE; imem_addr SHALL equal the PC at all times.
REQ-005 In LOAD, imem_rdata SHALL be captured into an internal instruction register.
REQ-006 Instruction register fields SHALL stay constant until the next LOAD.
REQ-007 Opcodes 000, 001, 100, 101, 110 and 111 SHALL be executable; 010 SHALL be NOP and 011 SHALL be HALT.
REQ-008 In ISSUE, issue_valid=1 and op_code SHALL equal the instruction register opcode; elem_idx SHALL start at 0.
REQ-009 In ISSUE with stall=0, elem_idx SHALL increment by 1 per cycle.
REQ-010 When elem_idx equals the count field and stall=0, elem_idx SHALL return to 0, the PC SHALL increment, and the next state SHALL be FETCH.
REQ-011 The element count SHALL be the count field + 1, giving 1 to 32 elements.
REQ-012 When issue_valid=0, op_code SHALL be 3'b010 so that the control unit asserts no write enables.
REQ-013 A NOP SHALL increment the PC with no issue cycle.
REQ-014 HALT SHALL not increment the PC.
REQ-015 PC increment SHALL wrap 255->0.
REQ-016 elem_addr SHALL wrap modulo 256.
REQ-017 stall=1 in any state SHALL hold the state, PC, elem_idx and instruction register.
REQ-018 During stall, issue_valid SHALL remain as it was in the stalled state (still 1 in ISSUE).
REQ-019 start SHALL be ignored in every state except IDLE.
REQ-020 Latency SHALL be: start sampled at edge k -> FETCH at k+1, LOAD at k+2, first issue_valid at k+3 (absent stall).
REQ-021 done SHALL be high only in DONE, for exactly one cycle.
REQ-022 busy SHALL be 0 in IDLE only.
REQ-023 All outputs except elem_addr SHALL be registered or decoded directly from state registers; elem_addr MAY be combinational base + elem_idx.

Reset
REQ-024 rst_n=0 SHALL immediately force the following, regardless of the clock:
- state=IDLE.
- PC=0, so imem_addr=0.
- instruction register=0.
- elem_idx=0.
- issue_valid=0, op_code=3'b010.
- busy=0, done=0.
- elem_addr=0.
REQ-025 An assertion of rst_n=0 mid-ISSUE SHALL abort the instruction with no further issue.
REQ-026 After rst_n is released, the block SHALL remain in IDLE until start is sampled.

Verification
REQ-027 The bench SHALL cover the following scenarios:
- Single instruction: memory[0]=16'h0310 (opcode 000, count 3, base 0x10), memory[1]=HALT; start pulse -> 4 issue cycles with elem_addr 0x10..0x13 and op_code 000, then FETCH/LOAD, then done pulse; total start-to-done = 10 cycles.
- Stall: assert stall for 2 cycles at elem_idx=1 of a 4-element op -> elem_idx holds at 1 for 3 cycles with issue_valid=1, then continues to 2, 3; total issue cycles = 6.
- NOP/HALT decode: memory[0]=NOP, memory[1]=opcode 101 with count 0, memory[2]=HALT -> exactly 1 issue cycle with op_code 101, PC sequence 0,1,2; op_code=010 whenever issue_valid=0.
- Wrap: base 0xFE with count 3 -> elem_addr FE, FF, 00, 01; an instruction at address 255 followed by HALT at address 0 -> PC wraps to 0.
- Mid-operation reset: rst_n low at elem_idx=2 -> same-cycle busy=0, issue_valid=0, op_code=010; after release, no activity until start; start asserted while busy -> ignored.

Source files
------------

// File: rtl/instr_sequencer.sv
// Vector instruction sequencer: fetches 16-bit words from a synchronous imem and
// issues one control-unit op per vector element; stall freezes every register.
module instr_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [2:0]  op_code,
  output logic        issue_valid,
  output logic [4:0]  elem_idx,
  output logic [7:0]  elem_addr,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [2:0] OP_NOP  = 3'b010;
  localparam logic [2:0] OP_HALT = 3'b011;

  logic [2:0]  state;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [4:0]  idx;
  logic [2:0]  ld_op;

  // In LOAD the memory word for the current PC is on imem_rdata, so decode it directly.
  assign ld_op = imem_rdata[15:13];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= 8'd0;
      ir    <= 16'd0;
      idx   <= 5'd0;
    end else if (!stall) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= 8'd0;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          ir  <= imem_rdata;
          idx <= 5'd0;
          if (ld_op == OP_NOP) begin
            pc    <= pc + 8'd1;
            state <= S_FETCH;
          end else if (ld_op == OP_HALT) begin
            state <= S_DONE;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (idx == ir[12:8]) begin
            idx   <= 5'd0;
            pc    <= pc + 8'd1;
            state <= S_FETCH;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_addr   = pc;
  assign issue_valid = (state == S_ISSUE);
  // Outside ISSUE the control unit sees NOP so it never asserts a write enable.
  assign op_code     = issue_valid ? ir[15:13] : OP_NOP;
  assign elem_idx    = idx;
  assign elem_addr   = ir[7:0] + {3'b000, idx};
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

endmodule
